// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, state width
// and constant helpers used to size the sequencer's counters.
package pll_lock_sequencer_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Width able to hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the clk domain.
module pll_lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic pll_lock,
   output logic lock_s
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         meta   <= pll_lock;
         lock_s <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: resets the PLL, waits for lock, checks lock stability,
// releases the downstream reset, and retries or gives up on repeated failures.
module pll_lock_sequencer
   import pll_lock_sequencer_pkg::*;
#(
   parameter int PLL_RESET_CYCLES   = 16,
   parameter int LOCK_TIMEOUT       = 27000,
   parameter int LOCK_STABLE_CYCLES = 256,
   parameter int MAX_RETRIES        = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               restart,
   input  logic               pll_lock,
   output logic               pll_reset,
   output logic               sys_rst,
   output logic               ready,
   output logic               fail,
   output logic               lost_lock,
   output logic [7:0]         loss_count,
   output logic [STATE_W-1:0] state
);

   localparam int MAX_T   = max3(PLL_RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
   localparam int CNT_W   = cnt_width(MAX_T);
   localparam int RETRY_W = cnt_width(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   logic               lock_s;
   state_t             cur, nxt;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [RETRY_W-1:0] retry, retry_n, retry_inc;
   logic [7:0]         loss_n;
   logic               lost_n;

   pll_lock_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .pll_lock (pll_lock),
      .lock_s   (lock_s)
   );

   assign retry_inc = retry + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur        <= ST_RESET_PLL;
         cnt        <= '0;
         retry      <= '0;
         loss_count <= 8'd0;
         lost_lock  <= 1'b0;
      end else begin
         cur        <= nxt;
         cnt        <= cnt_n;
         retry      <= retry_n;
         loss_count <= loss_n;
         lost_lock  <= lost_n;
      end
   end

   always_comb begin
      nxt     = cur;
      cnt_n   = cnt;
      retry_n = retry;
      loss_n  = loss_count;
      lost_n  = 1'b0;
      if (restart) begin
         // Full re-run; the loss history survives a restart.
         nxt     = ST_RESET_PLL;
         cnt_n   = '0;
         retry_n = '0;
      end else begin
         case (cur)
            ST_RESET_PLL: begin
               if (cnt == RST_LAST) begin
                  nxt   = ST_WAIT_LOCK;
                  cnt_n = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               // Lock is tested first so it wins over a coincident timeout.
               if (lock_s) begin
                  nxt   = ST_STABILIZE;
                  cnt_n = '0;
               end else if (cnt == TO_LAST) begin
                  cnt_n   = '0;
                  retry_n = retry_inc;
                  nxt     = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            ST_STABILIZE: begin
               if (!lock_s) begin
                  nxt   = ST_WAIT_LOCK;
                  cnt_n = '0;
               end else if (cnt == STB_LAST) begin
                  nxt     = ST_RUN;
                  cnt_n   = '0;
                  retry_n = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  nxt    = ST_RESET_PLL;
                  cnt_n  = '0;
                  lost_n = 1'b1;
                  if (loss_count != 8'hFF) loss_n = loss_count + 8'd1;
               end
            end
            ST_FAIL: begin
               cnt_n = '0;
            end
            default: begin
               nxt   = ST_RESET_PLL;
               cnt_n = '0;
            end
         endcase
      end
   end

   // Outputs decode the state register only; nothing reaches them from pll_lock.
   assign state     = cur;
   assign pll_reset = (cur == ST_RESET_PLL) || (cur == ST_FAIL);
   assign sys_rst   = (cur != ST_RUN);
   assign ready     = (cur == ST_RUN);
   assign fail      = (cur == ST_FAIL);

endmodule
